div_nr_sequencer: RTL and testbench

Sequential controller that computes a floating-point quotient N/D by Newton-Raphson reciprocal iteration on a single shared multiplier and a single shared adder/subtractor, instead of one unrolled hardware unit per step. It captures the already-normalized operands, issues the seed, iteration and final-multiply operations one at a time over start/done handshakes, holds the intermediate values, and presents the signed 32-bit quotient with a one-cycle done pulse. It sits between the operand normalizer and the external `mul32` / `AdditionStage32` instances it owns while busy.

---
 rtl/div_nr_sequencer.sv | 157 +++++++++++++++
 tb/tb_div_nr_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_nr_sequencer.sv
// rtl/div_nr_sequencer.sv - Newton-Raphson divide sequencer driving one shared multiplier and one shared subtractor
module div_nr_sequencer #(
  parameter int          ITERS = 4,
  parameter logic [31:0] C1    = 32'h0AB4B4B4,
  parameter logic [31:0] C2    = 32'h09F0F0F0,
  parameter logic [31:0] TWO   = 32'h00800000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] n_in,
  input  logic [31:0] d_in,
  input  logic        sign_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        dz,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_start,
  input  logic        mul_done,
  input  logic [31:0] mul_res,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_sub,
  output logic        add_start,
  input  logic        add_done,
  input  logic [31:0] add_res
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED_MUL, S_SEED_ADD, S_IT_MUL1, S_IT_ADD, S_IT_MUL2, S_FIN_MUL, S_OUT
  } state_t;

  localparam logic [2:0] IT_LAST = 3'(ITERS - 1);

  state_t      state_q, state_d;
  logic        wait_q, wait_d;
  logic [31:0] n_q, n_d, d_q, d_d, x_q, x_d, t_q, t_d, result_q, result_d;
  logic        s_q, s_d, dz_q, dz_d;
  logic [2:0]  it_q, it_d;
  logic        is_mul, is_add, unit_done;

  // Route operands to the shared units; operands stay stable across ISSUE and WAIT.
  always_comb begin
    mul_a  = '0;
    mul_b  = '0;
    add_a  = '0;
    add_b  = '0;
    is_mul = 1'b0;
    is_add = 1'b0;
    case (state_q)
      S_SEED_MUL: begin is_mul = 1'b1; mul_a = C2;  mul_b = d_q; end
      S_SEED_ADD: begin is_add = 1'b1; add_a = C1;  add_b = t_q; end
      S_IT_MUL1:  begin is_mul = 1'b1; mul_a = x_q; mul_b = d_q; end
      S_IT_ADD:   begin is_add = 1'b1; add_a = TWO; add_b = t_q; end
      S_IT_MUL2:  begin is_mul = 1'b1; mul_a = x_q; mul_b = t_q; end
      S_FIN_MUL:  begin is_mul = 1'b1; mul_a = n_q; mul_b = x_q; end
      default:    ;
    endcase
  end

  assign mul_start = is_mul & ~wait_q;
  assign add_start = is_add & ~wait_q;
  assign add_sub   = is_add;
  // Only the unit owned by the current state, and only while waiting, may complete it.
  assign unit_done = wait_q & ((is_mul & mul_done) | (is_add & add_done));
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_OUT);
  assign result    = result_q;
  assign dz        = dz_q;

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    n_d      = n_q;
    d_d      = d_q;
    x_d      = x_q;
    t_d      = t_q;
    s_d      = s_q;
    it_d     = it_q;
    result_d = result_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d    = n_in;
          d_d    = d_in;
          s_d    = sign_in;
          it_d   = 3'd0;
          wait_d = 1'b0;
          if (d_in[30:0] == 31'd0) begin
            state_d  = S_OUT;
            result_d = {sign_in, 8'hFF, 23'd0};
            dz_d     = 1'b1;
          end else begin
            state_d = S_SEED_MUL;
          end
        end
      end
      S_OUT: state_d = S_IDLE;
      default: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else if (unit_done) begin
          wait_d = 1'b0;
          case (state_q)
            S_SEED_MUL: begin t_d = mul_res; state_d = S_SEED_ADD; end
            S_SEED_ADD: begin x_d = add_res; state_d = S_IT_MUL1;  end
            S_IT_MUL1:  begin t_d = mul_res; state_d = S_IT_ADD;   end
            S_IT_ADD:   begin t_d = add_res; state_d = S_IT_MUL2;  end
            S_IT_MUL2: begin
              x_d     = mul_res;
              it_d    = it_q + 3'd1;
              state_d = (it_q == IT_LAST) ? S_FIN_MUL : S_IT_MUL1;
            end
            S_FIN_MUL: begin
              result_d = {s_q, mul_res[30:0]};
              dz_d     = 1'b0;
              state_d  = S_OUT;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wait_q   <= 1'b0;
      n_q      <= '0;
      d_q      <= '0;
      x_q      <= '0;
      t_q      <= '0;
      s_q      <= 1'b0;
      it_q     <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      n_q      <= n_d;
      d_q      <= d_d;
      x_q      <= x_d;
      t_q      <= t_d;
      s_q      <= s_d;
      it_q     <= it_d;
      result_q <= result_d;
      dz_q     <= dz_d;
    end
  end

endmodule

// File: tb/tb_div_nr_sequencer.sv
// tb/tb_div_nr_sequencer.sv - directed vector bench for div_nr_sequencer with latency-programmable unit models
module tb_div_nr_sequencer;

  localparam int          ITERS = 4;
  localparam logic [31:0] C1    = 32'h0AB4B4B4;
  localparam logic [31:0] C2    = 32'h09F0F0F0;
  localparam logic [31:0] TWO   = 32'h00800000;

  logic        clk, rst, start, sign_in;
  logic [31:0] n_in, d_in;
  logic        busy, done, dz, mul_start, add_start, add_sub, mul_done, add_done;
  logic [31:0] result, mul_a, mul_b, add_a, add_b, mul_res, add_res;

  div_nr_sequencer #(.ITERS(ITERS), .C1(C1), .C2(C2), .TWO(TWO)) dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in), .d_in(d_in), .sign_in(sign_in),
    .busy(busy), .done(done), .result(result), .dz(dz),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_done(mul_done), .mul_res(mul_res),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_start(add_start),
    .add_done(add_done), .add_res(add_res)
  );

  typedef struct {
    bit          is_add;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
  } op_t;

  typedef struct {
    logic [31:0] n;
    logic [31:0] d;
    bit          s;
    int          lm;
    int          la;
    bit          restart;
    bit          stray;
    logic [31:0] fin;
    int          exp_cyc;
    logic [31:0] exp_res;
    bit          exp_dz;
    int          exp_nmul;
    int          exp_nadd;
  } vec_t;

  op_t         log_q[$];
  op_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc_cnt = 0;
  int          base = 0;
  int          mul_cnt = 0, add_cnt = 0, mul_idx = 0, add_idx = 0;
  int          mul_lat = 1, add_lat = 1;
  int          stray_add_cyc = -1, stray_mul_cyc = -1;
  int          proto_bad = 0;
  logic [31:0] fin_res = '0, mul_pend = '0, add_pend = '0;
  vec_t        vt[7];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Unit models: done pulse L cycles after the strobe, plus optional stray pulses.
  initial begin
    int rel;
    mul_done = 1'b0;
    add_done = 1'b0;
    mul_res  = '0;
    add_res  = '0;
    forever begin
      @(negedge clk);
      rel = cyc_cnt - base;
      mul_done = 1'b0;
      add_done = 1'b0;
      if (mul_cnt > 0) begin
        mul_cnt--;
        if (mul_cnt == 0) begin mul_done = 1'b1; mul_res = mul_pend; end
      end
      if (add_cnt > 0) begin
        add_cnt--;
        if (add_cnt == 0) begin add_done = 1'b1; add_res = add_pend; end
      end
      if (mul_start === 1'b1 && add_start === 1'b1) proto_bad++;
      if (mul_start === 1'b1) begin
        log_q.push_back('{1'b0, mul_a, mul_b, rel});
        mul_pend = (mul_idx == 2 * ITERS + 1) ? fin_res : 32'h01000000 + 32'(mul_idx);
        mul_idx++;
        mul_cnt = mul_lat;
      end
      if (add_start === 1'b1) begin
        log_q.push_back('{1'b1, add_a, add_b, rel});
        if (add_sub !== 1'b1) proto_bad++;
        add_pend = 32'h02000000 + 32'(add_idx);
        add_idx++;
        add_cnt = add_lat;
      end
      if (rel == stray_add_cyc) begin add_done = 1'b1; add_res = 32'hDEADBEEF; end
      if (rel == stray_mul_cyc) begin mul_done = 1'b1; mul_res = 32'h0BADF00D; end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Expected operation stream: algorithm order with the model's synthetic results.
  task automatic build_exp(input vec_t v);
    logic [31:0] t, x;
    int c, mi, ai;
    exp_q.delete();
    if (v.d[30:0] == 31'd0) return;
    c = 1; mi = 0; ai = 0;
    exp_q.push_back('{1'b0, C2, v.d, c}); c += v.lm + 1; t = 32'h01000000 + 32'(mi); mi++;
    exp_q.push_back('{1'b1, C1, t, c});   c += v.la + 1; x = 32'h02000000 + 32'(ai); ai++;
    for (int i = 0; i < ITERS; i++) begin
      exp_q.push_back('{1'b0, x, v.d, c}); c += v.lm + 1; t = 32'h01000000 + 32'(mi); mi++;
      exp_q.push_back('{1'b1, TWO, t, c}); c += v.la + 1; t = 32'h02000000 + 32'(ai); ai++;
      exp_q.push_back('{1'b0, x, t, c});   c += v.lm + 1; x = 32'h01000000 + 32'(mi); mi++;
    end
    exp_q.push_back('{1'b0, v.n, x, c});
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int done_cyc, busy_bad, held_bad, mism, nmul, nadd, rel, pb0;
    logic [31:0] got_res;
    logic        got_dz;
    build_exp(v);
    @(negedge clk);
    mul_lat = v.lm; add_lat = v.la; fin_res = v.fin;
    mul_idx = 0; add_idx = 0; mul_cnt = 0; add_cnt = 0;
    stray_add_cyc = v.stray ? 6 : -1;
    stray_mul_cyc = -1;
    log_q.delete();
    pb0 = proto_bad;
    n_in = v.n; d_in = v.d; sign_in = v.s; start = 1'b1;
    base = cyc_cnt;
    done_cyc = -1; busy_bad = 0; got_res = '0; got_dz = 1'b0;
    for (int k = 0; k < 300 && done_cyc < 0; k++) begin
      @(negedge clk);
      rel = cyc_cnt - base;
      start = v.restart && (rel == 5 || rel == 20);
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin done_cyc = rel; got_res = result; got_dz = dz; end
    end
    start = 1'b0;
    chk($sformatf("v%0d_done_cycle", id), done_cyc, v.exp_cyc);
    chk($sformatf("v%0d_result", id), got_res, v.exp_res);
    chk($sformatf("v%0d_dz", id), {31'd0, got_dz}, {31'd0, v.exp_dz});
    chk($sformatf("v%0d_busy_window", id), busy_bad, 0);
    @(negedge clk);
    chk($sformatf("v%0d_idle_after", id), {30'd0, busy, done}, 32'd0);
    held_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (result !== v.exp_res || dz !== v.exp_dz) held_bad++;
    end
    chk($sformatf("v%0d_result_held", id), held_bad, 0);
    nmul = 0; nadd = 0; mism = 0;
    foreach (log_q[i]) if (log_q[i].is_add) nadd++; else nmul++;
    chk($sformatf("v%0d_mul_count", id), nmul, v.exp_nmul);
    chk($sformatf("v%0d_add_count", id), nadd, v.exp_nadd);
    if (log_q.size() != exp_q.size()) mism++;
    else foreach (exp_q[i])
      if (log_q[i].is_add != exp_q[i].is_add || log_q[i].a !== exp_q[i].a ||
          log_q[i].b !== exp_q[i].b || log_q[i].cyc != exp_q[i].cyc) mism++;
    chk($sformatf("v%0d_op_sequence_errors", id), mism, 0);
    chk($sformatf("v%0d_strobe_protocol_errors", id), proto_bad - pb0, 0);
  endtask

  initial begin
    int rel;
    rst = 1'b1; start = 1'b0; n_in = '0; d_in = '0; sign_in = 1'b0;

    //        n             d             s  lm la rs st fin           cyc res           dz nm na
    vt[0] = '{32'h12345678, 32'h00400000, 0, 1, 1, 0, 0, 32'h7F123456, 31, 32'h7F123456, 0, 10, 5};
    vt[1] = '{32'h3F000000, 32'h00600000, 1, 3, 2, 0, 0, 32'h00ABCDEF, 56, 32'h80ABCDEF, 0, 10, 5};
    vt[2] = '{32'h55555555, 32'h80000000, 1, 1, 1, 0, 0, 32'h00000000, 1,  32'hFF800000, 1, 0,  0};
    vt[3] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1, 1, 1, 0, 0, 32'h7F123456, 31, 32'hFF123456, 0, 10, 5};
    vt[4] = '{32'h01020304, 32'h00400000, 0, 1, 1, 1, 1, 32'h11111111, 31, 32'h11111111, 0, 10, 5};
    vt[5] = '{32'h00000000, 32'h00000000, 0, 2, 2, 0, 0, 32'h00000000, 1,  32'h7F800000, 1, 0,  0};
    vt[6] = '{32'h40000000, 32'h00500000, 0, 2, 1, 0, 0, 32'h8ABCDEF0, 41, 32'h0ABCDEF0, 0, 10, 5};

    repeat (3) @(negedge clk);
    chk("reset_ctrl", {26'd0, busy, done, dz, mul_start, add_start, add_sub}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_operands", mul_a | mul_b | add_a | add_b, 32'd0);
    rst = 1'b0;

    foreach (vt[i]) run_vec(i, vt[i]);

    // Reset in the middle of an operation, then a late completion pulse.
    @(negedge clk);
    mul_lat = 1; add_lat = 1; fin_res = 32'h12121212;
    mul_idx = 0; add_idx = 0; mul_cnt = 0; add_cnt = 0;
    stray_add_cyc = -1; stray_mul_cyc = 14;
    n_in = 32'h22222222; d_in = 32'h00400000; sign_in = 1'b1; start = 1'b1;
    base = cyc_cnt;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rel = cyc_cnt - base;
    chk("midop_cycle", rel, 12);
    chk("midop_busy_before_reset", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midop_reset_ctrl", {26'd0, busy, done, dz, mul_start, add_start, add_sub}, 32'd0);
    chk("midop_reset_result", result, 32'd0);
    chk("midop_reset_operands", mul_a | mul_b | add_a | add_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_done_ignored", {29'd0, busy, mul_start, add_start}, 32'd0);
    @(negedge clk);
    chk("late_done_still_idle", {30'd0, busy, done}, 32'd0);
    stray_mul_cyc = -1;

    run_vec(7, vt[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
